// File: rtl/gate_serial8.sv
// Bit-serial gate unit: evaluates NOT/AND/OR/XOR/NAND/NOR one bit per cycle, LSB first.
// Optional: define GATE_SERIAL8_XNOR_EN to make op 6 a legal XNOR.
module gate_serial8 #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic [2:0]       op_q;
    logic             err_q;
    logic [CNTW-1:0]  cnt_q;
    logic             r_bit;

    function automatic logic op_illegal(input logic [2:0] o);
`ifdef GATE_SERIAL8_XNOR_EN
        return (o == 3'd7);
`else
        return (o >= 3'd6);
`endif
    endfunction

    function automatic logic gate_bit(input logic [2:0] o, input logic x, input logic y);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
`ifdef GATE_SERIAL8_XNOR_EN
            3'd6:    return ~(x ^ y);
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Illegal jobs shift in zeros so s ends at 0 with identical timing.
    assign r_bit = err_q ? 1'b0 : gate_bit(op_q, a_q[0], b_q[0]);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= e1;
                        b_q   <= e2;
                        op_q  <= op;
                        err_q <= op_illegal(op);
                        s_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    s_q   <= {r_bit, s_q[WIDTH-1:1]};
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    assign s   = s_q;
    assign err = err_q;

endmodule

// File: tb/tb_gate_serial8.sv
// Self-checking bench for gate_serial8: directed vector table, reset/backpressure
// sequences, and randomized back-to-back jobs against a word-level model.
module tb_gate_serial8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] e1, e2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             err;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    gate_serial8 #(.WIDTH(WIDTH), .CNTW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .e1(e1), .e2(e2), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Word-level reference: returns {err, s}.
    function automatic logic [WIDTH:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        case (o)
            3'd0: return {1'b0, ~x};
            3'd1: return {1'b0, x & y};
            3'd2: return {1'b0, x | y};
            3'd3: return {1'b0, x ^ y};
            3'd4: return {1'b0, ~(x & y)};
            3'd5: return {1'b0, ~(x | y)};
`ifdef GATE_SERIAL8_XNOR_EN
            3'd6: return {1'b0, ~(x ^ y)};
`endif
            default: return {1'b1, {WIDTH{1'b0}}};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job: accept, count latency, optionally hold backpressure, then hand off.
    task automatic do_job(input logic [2:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp_s,
                          input logic exp_err, input int hold);
        int lat;
        logic [WIDTH-1:0] held_s;
        check("in_ready_before_accept", in_ready, 1'b1);
        op = o; e1 = x; e2 = y; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        e1 = WIDTH'($urandom); e2 = WIDTH'($urandom); op = 3'($urandom);
        check("in_ready_after_accept", in_ready, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, WIDTH);
        check("result_s", s, exp_s);
        check("result_err", err, exp_err);
        held_s = s;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_s", s, held_s);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 1'b0);
        check("handoff_in_ready", in_ready, 1'b1);
        check("handoff_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        logic [WIDTH-1:0] s;
        logic             err;
        int               hold;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int seen;
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] exp_v;
        int last_acc, cyc, njobs, nres;

        vecs[0] = '{3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0, 0};
        vecs[1] = '{3'd0, 8'hA5, 8'hFF, 8'h5A, 1'b0, 0};
        vecs[2] = '{3'd5, 8'h0F, 8'h30, 8'hC0, 1'b0, 0};
        vecs[3] = '{3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 0};
        vecs[4] = '{3'd3, 8'h55, 8'hFF, 8'hAA, 1'b0, 5};
        vecs[5] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 0};
`ifdef GATE_SERIAL8_XNOR_EN
        vecs[6] = '{3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0, 0};
`else
        vecs[6] = '{3'd6, 8'hF0, 8'h3C, 8'h00, 1'b1, 0};
`endif

        rst_n = 1'b0; in_valid = 1'b1; op = 3'd1; e1 = '1; e2 = '1; out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_s", s, '0);
        check("reset_err", err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            do_job(vecs[i].op, vecs[i].e1, vecs[i].e2, vecs[i].s, vecs[i].err, vecs[i].hold);

        // Reset during the 4th SHIFT cycle of an OR job discards it.
        op = 3'd2; e1 = 8'h01; e2 = 8'h80; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_in_ready", in_ready, 1'b1);
        check("midreset_s", s, '0);
        check("midreset_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midreset_no_output", seen, 0);
        do_job(3'd1, 8'hFF, 8'h0F, 8'h0F, 1'b0, 0);

        // Back-to-back random jobs with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 3'($urandom); e1 = WIDTH'($urandom); e2 = WIDTH'($urandom);
        last_acc = -1; njobs = 0; nres = 0; cyc = 0;
        while (nres < 20 && cyc < 2000) begin
            logic acc, res;
            acc = in_valid && in_ready;
            res = out_valid && out_ready;
            if (acc) exp_q.push_back(model(op, e1, e2));
            if (res) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 1'b1, 1'b0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("b2b_s", s, exp_v[WIDTH-1:0]);
                    check("b2b_err", err, exp_v[WIDTH]);
                end
                nres++;
            end
            tick();
            if (acc) begin
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, WIDTH + 2);
                last_acc = cyc;
                njobs++;
                op = 3'($urandom); e1 = WIDTH'($urandom); e2 = WIDTH'($urandom);
            end
            cyc++;
        end
        check("b2b_completed", nres, 20);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
